fft_result_drain: RTL and testbench

Output stage of the DFT engine: buffers the accumulated complex results (real[31:16], imag[15:0]) emitted once per k index and drains them to the AXI write channel in bursts. It sits directly downstream of the accumulation unit and k counter, and replaces direct AXI bridge read-back of RAM for result egress. Burst length and AWBURST encoding match the top-level `[N:0]` burst field.

---
 rtl/fft_result_drain.sv | 149 ++++++++++++++
 tb/tb_fft_result_drain.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_result_drain.sv
// fft_result_drain: buffers accumulated complex results {real, imag} in a
// FIFO and drains them to the AXI write channel in bursts of up to 2^N beats.
// Optional feature: define FFT_DRAIN_OVF_DETECT_EN to enable the sticky
// overflow flag o_ovf; otherwise o_ovf is tied low.
module fft_result_drain #(
  parameter int unsigned N          = 4,
  parameter int unsigned DEPTH_LOG2 = 5
) (
  input  logic          clk,
  input  logic          n_Reset,
  input  logic          i_start,
  input  logic [11:0]   i_samp_number,
  input  logic [31:0]   i_data,
  input  logic          i_valid,
  output logic          o_full,
  output logic [31:0]   AWDATA,
  output logic          AWVALID,
  input  logic          AWREADY,
  output logic [N:0]    AWBURST,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_ovf
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned MAXB  = 1 << N;

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

  state_t                state;
  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2:0]   wr_ptr, rd_ptr, count;
  logic [DEPTH_LOG2:0]   wr_next, rd_next, count_next;
  logic [DEPTH_LOG2:0]   len_ext;
  logic [12:0]           rem;
  logic [N:0]            beat, len;
  logic                  push, pop, flush;

  assign push  = i_valid && !o_full;
  assign pop   = AWVALID && AWREADY;
  assign flush = (state == DONE);
  assign count = wr_ptr - rd_ptr;

  // Head word is only meaningful when the FIFO holds data; zero otherwise.
  assign AWDATA = (count != '0) ? mem[rd_ptr[DEPTH_LOG2-1:0]] : '0;
  assign o_busy = (state != IDLE);

  // Next pointer values; o_full is registered from the post-edge count so it
  // lines up with the count seen in the same cycle.
  always_comb begin
    wr_next    = wr_ptr + (DEPTH_LOG2+1)'(push);
    rd_next    = flush ? wr_ptr : rd_ptr + (DEPTH_LOG2+1)'(pop);
    count_next = wr_next - rd_next;
  end

  // Burst length for the next burst: min(rem, 2^N).
  always_comb begin
    if (rem >= 13'(MAXB)) len = (N+1)'(MAXB);
    else                  len = rem[N:0];
    len_ext = {{(DEPTH_LOG2-N){1'b0}}, len};
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= i_data;
  end

  // FIFO pointers and full flag.
  always_ff @(posedge clk or negedge n_Reset) begin
    if (!n_Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_full <= 1'b0;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      o_full <= (count_next == (DEPTH_LOG2+1)'(DEPTH));
    end
  end

  // Frame/burst control FSM with registered AXI outputs.
  always_ff @(posedge clk or negedge n_Reset) begin
    if (!n_Reset) begin
      state   <= IDLE;
      rem     <= '0;
      beat    <= '0;
      AWBURST <= '0;
      AWVALID <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            rem <= {1'b0, i_samp_number};
            if (i_samp_number == '0) begin
              state  <= DONE;
              o_done <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (count >= len_ext) begin
            AWBURST <= len;
            beat    <= len;
            AWVALID <= 1'b1;
            state   <= BURST;
          end
        end
        BURST: begin
          if (pop) begin
            beat <= beat - 1'b1;
            rem  <= rem - 1'b1;
            if (beat == (N+1)'(1)) begin
              AWVALID <= 1'b0;
              AWBURST <= '0;
              if (rem == 13'd1) begin
                state  <= DONE;
                o_done <= 1'b1;
              end else begin
                state <= WAIT;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef FFT_DRAIN_OVF_DETECT_EN
  // Sticky overflow: dropped push or result arriving with no frame open.
  always_ff @(posedge clk or negedge n_Reset) begin
    if (!n_Reset)
      o_ovf <= 1'b0;
    else if (i_start)
      o_ovf <= 1'b0;
    else if (i_valid && (o_full || state == IDLE))
      o_ovf <= 1'b1;
  end
`else
  assign o_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_fft_result_drain.sv
// Testbench for fft_result_drain: scoreboard of pushed words and expected
// burst lengths, checked by a negedge monitor as beats are accepted.
module tb_fft_result_drain;

  localparam int unsigned N = 4;
  localparam int unsigned DL = 5;

  logic          clk = 1'b0;
  logic          n_Reset = 1'b1;
  logic          i_start = 1'b0;
  logic [11:0]   i_samp_number = '0;
  logic [31:0]   i_data = '0;
  logic          i_valid = 1'b0;
  logic          o_full;
  logic [31:0]   AWDATA;
  logic          AWVALID;
  logic          AWREADY = 1'b0;
  logic [N:0]    AWBURST;
  logic          o_busy;
  logic          o_done;
  logic          o_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [N:0]  burst_q[$];
  int          tb_rem = 0;
  bit          done_due = 0;
  bit          mon_en = 0;
  int          beat_left = 0;
  logic [N:0]  cur_len = '0;
  bit          prev_stall = 0;
  logic [31:0] prev_data = '0;
  logic        exp_ovf_drop;

  fft_result_drain #(.N(N), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .n_Reset(n_Reset), .i_start(i_start),
    .i_samp_number(i_samp_number), .i_data(i_data), .i_valid(i_valid),
    .o_full(o_full), .AWDATA(AWDATA), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .AWBURST(AWBURST), .o_busy(o_busy), .o_done(o_done), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  // Monitor: compares every accepted beat and the control outputs.
  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      if (o_done !== done_due) begin
        n_fail++;
        $display("FAIL done_pulse: got %b expected %b at %0t", o_done, done_due, $time);
      end
      done_due = 0;
      if (prev_stall) begin
        n_checks++;
        if (AWVALID !== 1'b1 || AWDATA !== prev_data) begin
          n_fail++;
          $display("FAIL stall_hold: got valid=%b data=%h expected valid=1 data=%h", AWVALID, AWDATA, prev_data);
        end
      end
      if (AWVALID !== 1'b1) begin
        n_checks++;
        if (AWBURST !== '0) begin
          n_fail++;
          $display("FAIL awburst_idle: got %0d expected 0", AWBURST);
        end
      end else if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got AWVALID=1 expected 0 (no data pending)");
      end
      if (AWVALID === 1'b1 && AWREADY === 1'b1 && exp_q.size() != 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        n_checks++;
        if (AWDATA !== e) begin
          n_fail++;
          $display("FAIL beat_data: got %h expected %h", AWDATA, e);
        end
        if (beat_left == 0) begin
          if (burst_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL burst_count: got extra burst expected none");
            cur_len = '0;
          end else begin
            cur_len = burst_q.pop_front();
          end
          beat_left = int'(cur_len);
        end
        n_checks++;
        if (AWBURST !== cur_len) begin
          n_fail++;
          $display("FAIL awburst_len: got %0d expected %0d", AWBURST, cur_len);
        end
        if (beat_left > 0) beat_left--;
        if (tb_rem > 0) begin
          tb_rem--;
          if (tb_rem == 0) done_due = 1;
        end
      end
      prev_stall = (AWVALID === 1'b1) && (AWREADY !== 1'b1);
      prev_data  = AWDATA;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int samp);
    int r;
    r = samp;
    while (r > 0) begin
      burst_q.push_back((r > 16) ? 5'd16 : 5'(r));
      r = (r > 16) ? r - 16 : 0;
    end
    tb_rem = samp;
    i_samp_number = 12'(samp);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic push_words(input int n, input bit record);
    for (int i = 0; i < n; i++) begin
      i_valid = 1'b1;
      i_data  = $urandom;
      if (record) exp_q.push_back(i_data);
      tick();
    end
    i_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int c;
    for (c = 0; c < 1000; c++) begin
      if (exp_q.size() == 0 && tb_rem == 0 && !done_due) break;
      tick();
    end
    n_checks++;
    if (c >= 1000) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d words pending expected 0", name, exp_q.size());
    end
    tick();
    n_checks++;
    if (o_busy !== 1'b0 || burst_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_end: got busy=%b bursts_left=%0d expected busy=0 bursts_left=0", name, o_busy, burst_q.size());
    end
  endtask

  task automatic test_reset();
    #1 n_Reset = 1'b0;
    #11;
    n_checks++;
    if ({AWVALID, AWBURST, AWDATA, o_full, o_busy, o_done, o_ovf} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b burst=%0d data=%h full=%b busy=%b done=%b ovf=%b expected all 0",
               AWVALID, AWBURST, AWDATA, o_full, o_busy, o_done, o_ovf);
    end
    n_Reset = 1'b1;
    tick();
    mon_en = 1;
  endtask

  task automatic test_single_burst();
    AWREADY = 1'b1;
    start_frame(16);
    n_checks++;
    if (o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_busy: got %b expected 1", o_busy);
    end
    push_words(16, 1);
    wait_drain("single");
  endtask

  task automatic test_multi_burst();
    AWREADY = 1'b1;
    start_frame(40);
    push_words(40, 1);
    wait_drain("multi");
  endtask

  task automatic test_stall_toggle();
    int c;
    AWREADY = 1'b0;
    start_frame(16);
    push_words(16, 1);
    for (c = 0; c < 200; c++) begin
      if (exp_q.size() == 0 && tb_rem == 0) break;
      AWREADY = ~AWREADY;
      tick();
    end
    AWREADY = 1'b1;
    wait_drain("toggle");
  endtask

  task automatic test_full_ovf();
    int c;
    AWREADY = 1'b0;
    start_frame(40);
    push_words(31, 1);
    n_checks++;
    if (o_full !== 1'b0 || o_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL full_at31: got full=%b ovf=%b expected full=0 ovf=0", o_full, o_ovf);
    end
    push_words(1, 1);
    n_checks++;
    if (o_full !== 1'b1) begin
      n_fail++;
      $display("FAIL full_at32: got %b expected 1", o_full);
    end
    push_words(1, 0);
    n_checks++;
    if (o_full !== 1'b1 || o_ovf !== exp_ovf_drop) begin
      n_fail++;
      $display("FAIL drop_33: got full=%b ovf=%b expected full=1 ovf=%b", o_full, o_ovf, exp_ovf_drop);
    end
    AWREADY = 1'b1;
    for (c = 0; c < 300; c++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    n_checks++;
    if (c >= 300 || tb_rem != 8) begin
      n_fail++;
      $display("FAIL full_drain32: got pending=%0d rem=%0d expected pending=0 rem=8", exp_q.size(), tb_rem);
    end
    push_words(8, 1);
    wait_drain("full");
  endtask

  task automatic test_empty_frame();
    i_samp_number = '0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    done_due = 1;
    n_checks++;
    if (o_busy !== 1'b1 || AWVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_done_state: got busy=%b valid=%b expected busy=1 valid=0", o_busy, AWVALID);
    end
    tick();
    wait_drain("empty");
  endtask

  task automatic test_reset_mid_burst();
    int c;
    AWREADY = 1'b1;
    start_frame(16);
    push_words(16, 1);
    for (c = 0; c < 100; c++) begin
      if (exp_q.size() <= 10) break;
      tick();
    end
    mon_en = 0;
    n_Reset = 1'b0;
    #1;
    n_checks++;
    if (c >= 100 || AWVALID !== 1'b0 || AWBURST !== '0 || o_busy !== 1'b0 || o_full !== 1'b0 || AWDATA !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got valid=%b burst=%0d busy=%b full=%b data=%h expected all 0 (wait=%0d)",
               AWVALID, AWBURST, o_busy, o_full, AWDATA, c);
    end
    exp_q.delete();
    burst_q.delete();
    tb_rem = 0;
    done_due = 0;
    beat_left = 0;
    prev_stall = 0;
    #1 n_Reset = 1'b1;
    tick();
    mon_en = 1;
    start_frame(16);
    push_words(16, 1);
    wait_drain("after_reset");
  endtask

  initial begin
`ifdef FFT_DRAIN_OVF_DETECT_EN
    exp_ovf_drop = 1'b1;
`else
    exp_ovf_drop = 1'b0;
`endif
    test_reset();
    test_single_burst();
    test_multi_burst();
    test_stall_toggle();
    test_full_ovf();
    test_empty_frame();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
